// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock.
//
// A rising edge on start loads din and runs IN_W shift steps, followed by
// one FINISH cycle that publishes the result.
//
// Parameters:
//   IN_W   - binary input width (2..20)
//   DIGITS - number of BCD output digits (1..6)
//   SAT    - 1: an overflowing value shows as all nines
//            0: the result is the value modulo 10^DIGITS
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   start - conversion request; only its rising edge matters
//   din   - unsigned binary input, sampled on the load cycle
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse when bcd/ovf have been updated
//   ovf   - last converted value was >= 10^DIGITS
//   bcd   - packed BCD result, units digit at [3:0]
module bin2bcd_seq #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned DIGITS = 2,
    parameter bit          SAT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       din,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int unsigned        LIMIT    = pow10(DIGITS);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(IN_W);
    localparam logic [ACC_W-1:0]   ALL_NINE = {DIGITS{4'h9}};

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_t;

    state_t             state_q;
    logic               st0_q, st1_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    bin_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_int_q;

    logic               start_edge;
    logic [31:0]        din_ext;
    logic               ovf_load;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [IN_W-1:0]    bin_shift;

    assign start_edge = st0_q & ~st1_q;
    // Constant compare; folds to 0 when din cannot reach 10^DIGITS.
    assign din_ext  = 32'(din);
    assign ovf_load = (din_ext >= LIMIT);

    // Add 3 to every digit >= 5 so the following left shift carries correctly.
    always_comb begin
        acc_adj = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end else begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4];
            end
        end
    end

    // Accumulator MSB falls off the top, leaving the value modulo 10^DIGITS.
    assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[IN_W-1]};
    assign bin_shift = {bin_q[IN_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            st0_q     <= 1'b0;
            st1_q     <= 1'b0;
            cnt_q     <= '0;
            bin_q     <= '0;
            acc_q     <= '0;
            ovf_int_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= '0;
        end else begin
            st0_q <= start;
            st1_q <= st0_q;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        bin_q     <= din;
                        acc_q     <= '0;
                        ovf_int_q <= ovf_load;
                        cnt_q     <= CNT_LOAD;
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    acc_q <= acc_shift;
                    bin_q <= bin_shift;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    bcd     <= (SAT && ovf_int_q) ? ALL_NINE : acc_q;
                    ovf     <= ovf_int_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three instances share clk/rst/start.
//   a: defaults (IN_W=7, DIGITS=2, SAT=1)
//   m: IN_W=7, DIGITS=2, SAT=0
//   w: IN_W=14, DIGITS=4, SAT=0
// Stimulus is driven and outputs sampled on the falling edge.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  din7;
    logic [13:0] din14;

    logic        busy_a, done_a, ovf_a;
    logic [7:0]  bcd_a;
    logic        busy_m, done_m, ovf_m;
    logic [7:0]  bcd_m;
    logic        busy_w, done_w, ovf_w;
    logic [15:0] bcd_w;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last observation window.
    int nd_a, nd_m, nd_w;
    int lat_a, lat_w;
    int nb_a;
    logic       pre_done_a;
    logic [7:0] pre_bcd_a;

    always #5 clk = ~clk;

    bin2bcd_seq dut_a (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din7),
        .busy (busy_a),
        .done (done_a),
        .ovf  (ovf_a),
        .bcd  (bcd_a)
    );

    bin2bcd_seq #(.IN_W(7), .DIGITS(2), .SAT(1'b0)) dut_m (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din7),
        .busy (busy_m),
        .done (done_m),
        .ovf  (ovf_m),
        .bcd  (bcd_m)
    );

    bin2bcd_seq #(.IN_W(14), .DIGITS(4), .SAT(1'b0)) dut_w (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din14),
        .busy (busy_w),
        .done (done_w),
        .ovf  (ovf_w),
        .bcd  (bcd_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watch n falling edges; j counts clocks after the posedge that sampled start.
    task automatic watch(input int n);
        nd_a = 0; nd_m = 0; nd_w = 0;
        lat_a = 0; lat_w = 0; nb_a = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (busy_a) nb_a++;
            if (done_a) begin
                nd_a++;
                if (nd_a == 1) lat_a = j;
            end
            if (done_m) nd_m++;
            if (done_w) begin
                nd_w++;
                if (nd_w == 1) lat_w = j;
            end
        end
    endtask

    // Called on a falling edge; start is high for exactly one rising edge.
    task automatic conv(input logic [6:0] v7, input logic [13:0] v14, input int win);
        din7  = v7;
        din14 = v14;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pre_done_a = done_a;
        pre_bcd_a  = bcd_a;
        watch(win);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        din7  = '0;
        din14 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_ovf", {31'b0, ovf_a}, 32'd0);
        check("rst_bcd_a", {24'b0, bcd_a}, 32'h0);
        check("rst_bcd_w", {16'b0, bcd_w}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 99 / 9999: in range everywhere
        conv(7'd99, 14'd9999, 20);
        check("c99_done_cnt", nd_a, 1);
        check("c99_latency", lat_a, 9);
        check("c99_busy_cycles", nb_a, 8);
        check("c99_bcd_a", {24'b0, bcd_a}, 32'h99);
        check("c99_ovf_a", {31'b0, ovf_a}, 32'd0);
        check("c99_bcd_m", {24'b0, bcd_m}, 32'h99);
        check("c9999_latency_w", lat_w, 16);
        check("c9999_bcd_w", {16'b0, bcd_w}, 32'h9999);
        check("c9999_ovf_w", {31'b0, ovf_w}, 32'd0);

        // 127 / 10000: overflow, saturate vs modulo
        conv(7'd127, 14'd10000, 20);
        check("c127_bcd_sat", {24'b0, bcd_a}, 32'h99);
        check("c127_ovf_sat", {31'b0, ovf_a}, 32'd1);
        check("c127_bcd_mod", {24'b0, bcd_m}, 32'h27);
        check("c127_ovf_mod", {31'b0, ovf_m}, 32'd1);
        check("c10000_bcd_w", {16'b0, bcd_w}, 32'h0000);
        check("c10000_ovf_w", {31'b0, ovf_w}, 32'd1);

        // start held high for 40 clocks: exactly one conversion
        din7  = 7'd45;
        din14 = 14'd0;
        start = 1'b1;
        watch(40);
        start = 1'b0;
        check("held_done_cnt", nd_a, 1);
        check("held_bcd", {24'b0, bcd_a}, 32'h45);
        check("held_ovf", {31'b0, ovf_a}, 32'd0);
        watch(2);

        // second pulse while busy is ignored; din change after load has no effect
        conv(7'd34, 14'd0, 3);
        din7  = 7'd12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(20);
        check("busy_ign_done_cnt", nd_a, 1);
        check("busy_ign_bcd", {24'b0, bcd_a}, 32'h34);
        conv(7'd12, 14'd0, 20);
        check("after_done_bcd", {24'b0, bcd_a}, 32'h12);
        check("after_done_cnt", nd_a, 1);

        // reset mid-conversion
        conv(7'd63, 14'd0, 4);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy_a}, 32'd0);
        check("mid_rst_bcd", {24'b0, bcd_a}, 32'h0);
        check("mid_rst_ovf_m", {31'b0, ovf_m}, 32'd0);
        watch(2);
        rst = 1'b1;
        watch(20);
        check("mid_rst_no_done", nd_a, 0);
        check("mid_rst_idle", {31'b0, busy_a}, 32'd0);
        conv(7'd5, 14'd0, 20);
        check("post_rst_bcd", {24'b0, bcd_a}, 32'h05);
        check("post_rst_latency", lat_a, 9);

        // zero input: full latency, no early exit
        conv(7'd0, 14'd0, 20);
        check("zero_bcd", {24'b0, bcd_a}, 32'h0);
        check("zero_ovf", {31'b0, ovf_a}, 32'd0);
        check("zero_latency", lat_a, 9);
        check("zero_done_cnt", nd_a, 1);

        // back-to-back: next edge lands in the cycle right after done
        conv(7'd10, 14'd0, 8);
        conv(7'd20, 14'd0, 8);
        check("b2b_10_done", {31'b0, pre_done_a}, 32'd1);
        check("b2b_10_bcd", {24'b0, pre_bcd_a}, 32'h10);
        conv(7'd59, 14'd0, 20);
        check("b2b_20_done", {31'b0, pre_done_a}, 32'd1);
        check("b2b_20_bcd", {24'b0, pre_bcd_a}, 32'h20);
        check("b2b_59_latency", lat_a, 9);
        check("b2b_59_bcd", {24'b0, bcd_a}, 32'h59);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Replaces the fixed 7-bit/2-digit converter in the stopwatch/watch display path.
- Generalised in input width and digit count. Adds overflow detection, a selectable saturate/modulo mode, and a busy/done handshake.
- Sits between the time counters and the 7-segment digit mux.

Parameters:
IN_W, 7, binary input width (2..20)
DIGITS, 2, number of BCD output digits (1..6)
SAT, 1, 1 = on overflow drive all digits to 9; 0 = output value modulo 10^DIGITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  conversion request; rising edge detected internally, level may be held
din  input  IN_W  unsigned binary value, sampled on the load cycle
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/ovf have been updated
ovf  output  1  last converted value was >= 10^DIGITS; held until the next done
bcd  output  4*DIGITS  packed BCD result, digit 0 (units) at [3:0]; held between conversions

Behaviour:
- Reset (rst=0, asynchronous):
  - busy=0, done=0, ovf=0, bcd=0.
  - Start edge flops st0/st1 cleared; FSM forced to IDLE; bit counter and shift register cleared.
  - Reset mid-conversion aborts it with no done pulse.
- Start detection:
  - st0<=start, st1<=st0 every clock; edge = st0 & ~st1.
  - Holding start high produces exactly one edge.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - busy=0.
  - On edge: load din into the binary shift register and zero the BCD accumulator (4*DIGITS bits).
  - Set ovf_int = (din >= 10^DIGITS), computed from a localparam constant.
  - Bit counter := IN_W. Go to SHIFT; busy=1 from this clock edge.
- SHIFT:
  - Each clock, every accumulator digit >= 5 gets +3.
  - Then {acc, bin} shifts left by 1; the acc MSB carry-out is discarded, which gives the modulo-10^DIGITS result.
  - Counter decrements; after the IN_W-th shift go to FINISH.
- FINISH:
  - One cycle: bcd <= (SAT && ovf_int) ? all digits 4'h9 : acc; ovf <= ovf_int.
  - done=1 for exactly this one cycle; busy=0 at the same edge. Return to IDLE.
- Latency:
  - start first sampled high at posedge k → load at posedge k+1.
  - Shifts at posedges k+2..k+1+IN_W.
  - bcd/ovf/done updated at posedge k+2+IN_W.
  - busy high from k+1 until k+2+IN_W.
- Edges arriving while busy or in FINISH are ignored (not queued).
- A new edge in the cycle right after done starts a new conversion normally.
- din changes after the load cycle have no effect on the result in progress.
- bcd and ovf change only at FINISH.
- din=0 → bcd=0, ovf=0 after the full IN_W+2 latency (no early exit).
- Width rules: the accumulator is exactly 4*DIGITS bits. If 2^IN_W-1 < 10^DIGITS, ovf is structurally 0.

Test Plan:
- Defaults, din=7'd99, start pulse 1 clk → done 9 clks after start sampled; bcd=8'h99, ovf=0, busy high 8 clks.
- Defaults SAT=1, din=7'd127 → bcd=8'h99, ovf=1. SAT=0, din=127 → bcd=8'h27, ovf=1.
- IN_W=14, DIGITS=4: din=9999 → bcd=16'h9999, ovf=0; din=10000 (SAT=0) → bcd=16'h0000, ovf=1.
- start held high 40 clks with din=45 → exactly one done pulse, bcd=8'h45. A second start pulse during busy (din=12) is ignored; the pulse after done converts 12 → 8'h12.
- rst low at mid-SHIFT of a din=63 conversion → outputs immediately 0, no done. After release, start with din=5 → bcd=8'h05 and prior state discarded.
- din=0 → bcd=0, ovf=0, done at full latency. Back-to-back conversions 10, 20, 59 → bcd 8'h10, 8'h20, 8'h59 in order.
